// File: rtl/cnt_pkg.sv
// Shared helpers for the synchronous up counter: log2, power-of-two test
// and the WIDTH-bit terminal value.
package cnt_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  // True when the modulus uses the full binary range, so a bare T-flop chain wraps naturally
  function automatic bit is_full_range(input int unsigned mod, input int unsigned width);
    return is_pow2(mod) && (clog2(mod) == width);
  endfunction

  // Terminal value MOD-1 computed at 32 bits; callers truncate to their width
  function automatic int unsigned last_value(input int unsigned mod);
    return mod - 1;
  endfunction

endpackage

// File: rtl/t_ff_ar.sv
// Toggle flop with asynchronous active-high reset and a synchronous load
// path that takes precedence over the toggle.
module t_ff_ar (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic d_sync,
  input  logic ld,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d_sync;
    end else if (t) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_up_sync.sv
// Synchronous modulo-MOD up counter built from T-flops with an AND carry
// chain; clear, saturating load and wrap share the flops' load path.
module counter_up_sync
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LAST      = WIDTH'(last_value(MOD));
  localparam bit               FULL_MOD  = is_full_range(MOD, WIDTH);

  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] tog_c;
  logic [WIDTH-1:0] ld_val_c;
  logic [WIDTH-1:0] load_sat_c;
  logic             ld_c;
  logic             wrap_c;
  logic             ovf_q;
  logic             ovf_d;

  assign count  = q_bits;
  assign wrap_c = en && (q_bits == LAST);

  // Bit i toggles when enabled and every lower bit is 1
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_carry
      if (gi == 0) begin : g_lsb
        assign tog_c[gi] = en;
      end else begin : g_upper
        assign tog_c[gi] = en & (&q_bits[gi-1:0]);
      end
    end
  endgenerate

  assign load_sat_c = (load_val > LAST) ? LAST : load_val;

  // Clear, load and non-binary wrap all force a value through the load path
  always_comb begin
    ld_c     = 1'b0;
    ld_val_c = '0;
    if (clr) begin
      ld_c     = 1'b1;
      ld_val_c = '0;
    end else if (load) begin
      ld_c     = 1'b1;
      ld_val_c = load_sat_c;
    end else if (!FULL_MOD && wrap_c) begin
      ld_c     = 1'b1;
      ld_val_c = '0;
    end
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      t_ff_ar u_tff (
        .clk    (clk),
        .rst    (rst),
        .t      (tog_c[gi]),
        .d_sync (ld_val_c[gi]),
        .ld     (ld_c),
        .q      (q_bits[gi])
      );
    end
  endgenerate

  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (load) begin
      ovf_d = ovf_q;
    end else if (wrap_c) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
  assign tc  = wrap_c & ~rst;

endmodule

// File: tb/tb_counter_up_sync.sv
// Scoreboard bench for counter_up_sync: a MOD=16 and a MOD=10 instance share
// stimulus; the driver queues expected state, a negedge monitor compares.
module tb_counter_up_sync;

  typedef struct packed {
    logic [3:0] cnt;
    logic       ovf;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  bit         run = 1'b1;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count16, count10;
  logic       tc16, tc10, ovf16, ovf10;

  exp_t        q16[$];
  exp_t        q10[$];
  int unsigned m16, m10;
  bit          o16, o10;
  int          errors = 0;
  int          checks = 0;

  counter_up_sync #(.WIDTH(4), .MOD(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .count(count16), .tc(tc16), .ovf(ovf16)
  );

  counter_up_sync #(.WIDTH(4), .MOD(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .count(count10), .tc(tc10), .ovf(ovf10)
  );

  always begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int unsigned mod, inout int unsigned c, inout bit o,
                                input bit e, input bit cl, input bit l, input int unsigned v);
    if (cl) begin
      c = 0;
      o = 1'b0;
    end else if (l) begin
      c = (v >= mod) ? mod - 1 : v;
    end else if (e) begin
      if (c == mod - 1) begin
        c = 0;
        o = 1'b1;
      end else begin
        c = c + 1;
      end
    end
  endfunction

  // Drive one cycle of inputs just after a rising edge and queue the state
  // the DUTs should show until the next edge.
  task automatic step(input bit e, input bit c, input bit l, input logic [3:0] v);
    @(posedge clk);
    #2;
    en       = e;
    clr      = c;
    load     = l;
    load_val = v;
    q16.push_back(exp_t'{cnt: 4'(m16), ovf: o16, tc: (m16 == 15) && e});
    q10.push_back(exp_t'{cnt: 4'(m10), ovf: o10, tc: (m10 == 9) && e});
    model(16, m16, o16, e, c, l, int'(v));
    model(10, m10, o10, e, c, l, int'(v));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q16.size() > 0) begin
        x = q16.pop_front();
        chk("count16", int'(count16), int'(x.cnt));
        chk("ovf16", int'(ovf16), int'(x.ovf));
        chk("tc16", int'(tc16), int'(x.tc));
      end
      if (q10.size() > 0) begin
        x = q10.pop_front();
        chk("count10", int'(count10), int'(x.cnt));
        chk("ovf10", int'(ovf10), int'(x.ovf));
        chk("tc10", int'(tc10), int'(x.tc));
        chk("range10", int'(count10 < 4'd10), 1);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    m16 = 0; m10 = 0; o16 = 1'b0; o10 = 1'b0;
    #12;
    chk("rst_count16", int'(count16), 0);
    chk("rst_ovf16", int'(ovf16), 0);
    chk("rst_tc16_gated", int'(tc16), 0);
    chk("rst_tc10_gated", int'(tc10), 0);
    #1;
    en  = 1'b0;
    rst = 1'b0;

    // Async reset mid-count with the clock stopped
    step(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (9) step(1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    @(negedge clk);
    chk("pre_rst_count16", int'(count16), 9);
    run = 1'b0;
    #2;
    en  = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_count16", int'(count16), 0);
    chk("async_ovf16", int'(ovf16), 0);
    chk("async_count10", int'(count10), 0);
    chk("async_tc10", int'(tc10), 0);
    m16 = 0; m10 = 0; o16 = 1'b0; o10 = 1'b0;
    #2;
    rst = 1'b0;
    en  = 1'b0;
    #3;
    run = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    chk("after_rst_count16", int'(count16), 3);
    chk("after_rst_count10", int'(count10), 3);
    chk("after_rst_ovf16", int'(ovf16), 0);

    // Full binary wrap: 17 enabled edges from 0
    step(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (17) step(1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    chk("wrap17_count16", int'(count16), 1);
    chk("wrap17_ovf16", int'(ovf16), 1);
    chk("wrap17_count10", int'(count10), 7);
    chk("wrap17_ovf10", int'(ovf10), 1);

    // Decimal wrap: 12 enabled edges from 0
    step(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (12) step(1'b1, 1'b0, 1'b0, 4'd0);
    idle();
    chk("wrap12_count10", int'(count10), 2);
    chk("wrap12_ovf10", int'(ovf10), 1);
    chk("wrap12_count16", int'(count16), 12);
    chk("wrap12_ovf16", int'(ovf16), 0);

    // Saturating load, tc at loaded terminal, load beats increment
    step(1'b1, 1'b0, 1'b1, 4'd13);
    idle();
    chk("sat_count10", int'(count10), 9);
    chk("sat_count16", int'(count16), 13);
    chk("sat_ovf10_kept", int'(ovf10), 1);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    chk("load_tc10", int'(tc10), 1);
    chk("load_tc16", int'(tc16), 0);
    step(1'b1, 1'b0, 1'b1, 4'd4);
    idle();
    chk("load_en_count10", int'(count10), 4);
    chk("load_en_count16", int'(count16), 4);

    // Clear with enable at terminal count drops ovf
    step(1'b0, 1'b0, 1'b1, 4'd15);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd15);
    idle();
    chk("pre_clr_count16", int'(count16), 15);
    chk("pre_clr_ovf16", int'(ovf16), 1);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    idle();
    chk("clr_count16", int'(count16), 0);
    chk("clr_ovf16", int'(ovf16), 0);
    repeat (3) idle();
    chk("hold_count16", int'(count16), 0);

    // Random mix of enable, clear and load
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
    end
    idle();

    repeat (4) @(negedge clk);
    #1;
    chk("queue16_drained", q16.size(), 0);
    chk("queue10_drained", q10.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
